calc1: RTL and testbench
========================

CALC1 -- requirements
Module: calc1

Interface
REQ-001 The block SHALL have port c_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset, sampled on the c_clk rising edge.
REQ-003 For each n in 1..4, the block SHALL have port reqn_cmd_in, input, 4 bits: command for port n.
REQ-004 For each n in 1..4, the block SHALL have port reqn_data_in, input, 32 bits: operand data for port n.
REQ-005 For each n in 1..4, the block SHALL have port out_respn, output, 2 bits: response code for port n.
REQ-006 For each n in 1..4, the block SHALL have port out_datan, output, 32 bits: result data for port n.

Function
REQ-007 The block SHALL implement four independent, identical request ports; activity on one port SHALL NOT affect timing or results of any other port.
REQ-008 Command codes SHALL be: 0 = no-op; 1 = add; 2 = subtract; 5 = shift left logical; 6 = shift right logical; all other codes are invalid.
REQ-009 Response codes SHALL be: 00 = no response; 01 = success; 10 = overflow/underflow; 11 = invalid command.
REQ-010 Each port SHALL run a 4-state FSM: IDLE, OP2, EXEC, RESP.
REQ-011 In IDLE at edge k, a nonzero cmd SHALL capture cmd and data_in as operand1 and move to OP2; a zero cmd SHALL keep the port in IDLE.
REQ-012 In OP2 at edge k+1, the port SHALL capture data_in as operand2 regardless of cmd_in and move to EXEC.
REQ-013 At edge k+2 the port SHALL compute the result and move to RESP; at edge k+3 it SHALL drive out_resp/out_data and return to IDLE.
REQ-014 Response and data SHALL be valid for exactly one cycle, from edge k+3 to edge k+4; outside that window out_resp SHALL be 00 and out_data SHALL be 0.
REQ-015 cmd_in values presented while the port is not IDLE SHALL be ignored; the earliest next accepted command SHALL be at edge k+3, back-to-back with the response.
REQ-016 Add SHALL be an unsigned 32-bit sum; a carry out of bit 31 SHALL give resp 10 with data 0, otherwise resp 01 with the sum.
REQ-017 Subtract SHALL be unsigned operand1 - operand2; operand2 > operand1 SHALL give resp 10 with data 0, otherwise resp 01 with the difference.
REQ-018 Shifts SHALL shift operand1 by operand2[4:0] with zero fill, ignoring operand2[31:5], and SHALL always give resp 01.
REQ-019 An invalid command SHALL follow the same timing, including the operand2 cycle, and give resp 11 with data 0.

Reset
REQ-020 While reset is low at a rising edge, all four FSMs SHALL go to IDLE, all captured operands and commands SHALL clear to 0, and all out_resp/out_data SHALL be 0 from that edge.
REQ-021 A reset asserted mid-operation SHALL abort the operation on every port with no response produced.
REQ-022 The first command SHALL be accepted at the first edge at which reset is high.

Verification
REQ-023 Port 1: cmd 1, data 0x00000001 at edge k, then data 0x00000002 at k+1 -> at k+3, out_resp1=01 and out_data1=0x00000003 for one cycle.
REQ-024 Port 2: add 0xFFFFFFFF + 0x00000001 -> out_resp2=10, out_data2=0.
REQ-025 Port 3: subtract 5 - 6 -> out_resp3=10, out_data3=0; subtract 6 - 5 -> out_resp3=01, out_data3=1.
REQ-026 Port 4: shift left 0x00000001 by 0x00000024 (effective 4) -> out_data4=0x00000010; shift right 0x80000000 by 31 -> out_data4=0x00000001; both with out_resp4=01.
REQ-027 All four ports issue cmd 3 at the same edge -> all out_resp=11 with data 0 at k+3; next, reset is driven low at k+2 of an add -> no response is produced, and all outputs are 0.

Source files
------------

// File: rtl/calc1_if.sv
// Request/response bundle for the four-port calculator (bus-side signals only).
// Latency: n/a (wiring only).
// Backpressure: none; responses are single-cycle pulses the requester must sample.
//
// Ports per n in 1..4:
//   reqn_cmd_in  [3:0]  command for port n
//   reqn_data_in [31:0] operand data for port n
//   out_respn    [1:0]  response code for port n
//   out_datan    [31:0] result data for port n
// master = requester side, slave = calculator side.
interface calc1_if;
    logic [3:0]  req1_cmd_in;
    logic [3:0]  req2_cmd_in;
    logic [3:0]  req3_cmd_in;
    logic [3:0]  req4_cmd_in;
    logic [31:0] req1_data_in;
    logic [31:0] req2_data_in;
    logic [31:0] req3_data_in;
    logic [31:0] req4_data_in;
    logic [1:0]  out_resp1;
    logic [1:0]  out_resp2;
    logic [1:0]  out_resp3;
    logic [1:0]  out_resp4;
    logic [31:0] out_data1;
    logic [31:0] out_data2;
    logic [31:0] out_data3;
    logic [31:0] out_data4;

    modport master (
        output req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in,
        output req1_data_in, req2_data_in, req3_data_in, req4_data_in,
        input  out_resp1, out_resp2, out_resp3, out_resp4,
        input  out_data1, out_data2, out_data3, out_data4
    );

    modport slave (
        input  req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in,
        input  req1_data_in, req2_data_in, req3_data_in, req4_data_in,
        output out_resp1, out_resp2, out_resp3, out_resp4,
        output out_data1, out_data2, out_data3, out_data4
    );
endinterface

// File: rtl/calc1.sv
// Four independent calculator ports: add/sub with overflow detect, logical shifts.
// Latency: command+operand1 at edge k, operand2 at k+1, one-cycle response at k+3.
// Backpressure: none; commands offered while a port is busy are dropped, next accept at k+3.
//
// Ports:
//   c_clk  - clock, all state on rising edge
//   reset  - synchronous active-low reset
//   bus    - calc1_if.slave: per-port cmd/data inputs, resp/data outputs
module calc1 (
    input  logic    c_clk,
    input  logic    reset,
    calc1_if.slave  bus
);
    localparam int NPORT = 4;

    typedef enum logic [1:0] {ST_IDLE, ST_OP2, ST_EXEC, ST_RESP} state_t;

    logic [NPORT-1:0][3:0]  cmd_i;
    logic [NPORT-1:0][31:0] data_i;
    logic [NPORT-1:0][1:0]  resp_o;
    logic [NPORT-1:0][31:0] dout_o;

    assign cmd_i[0]  = bus.req1_cmd_in;
    assign cmd_i[1]  = bus.req2_cmd_in;
    assign cmd_i[2]  = bus.req3_cmd_in;
    assign cmd_i[3]  = bus.req4_cmd_in;
    assign data_i[0] = bus.req1_data_in;
    assign data_i[1] = bus.req2_data_in;
    assign data_i[2] = bus.req3_data_in;
    assign data_i[3] = bus.req4_data_in;

    assign bus.out_resp1 = resp_o[0];
    assign bus.out_resp2 = resp_o[1];
    assign bus.out_resp3 = resp_o[2];
    assign bus.out_resp4 = resp_o[3];
    assign bus.out_data1 = dout_o[0];
    assign bus.out_data2 = dout_o[1];
    assign bus.out_data3 = dout_o[2];
    assign bus.out_data4 = dout_o[3];

    genvar g;
    generate
        for (g = 0; g < NPORT; g++) begin : g_port
            state_t      state_q;
            logic [3:0]  cmd_q;
            logic [31:0] op1_q;
            logic [31:0] op2_q;
            logic [1:0]  res_resp_q;
            logic [31:0] res_data_q;
            logic [1:0]  resp_q;
            logic [31:0] dout_q;

            logic [1:0]  res_resp_d;
            logic [31:0] res_data_d;
            logic [32:0] sum;

            // Result of the captured operation; sampled only in EXEC.
            always_comb begin
                res_resp_d = 2'b11;
                res_data_d = '0;
                sum        = {1'b0, op1_q} + {1'b0, op2_q};
                case (cmd_q)
                    4'd1: begin
                        if (sum[32]) begin
                            res_resp_d = 2'b10;
                        end else begin
                            res_resp_d = 2'b01;
                            res_data_d = sum[31:0];
                        end
                    end
                    4'd2: begin
                        if (op2_q > op1_q) begin
                            res_resp_d = 2'b10;
                        end else begin
                            res_resp_d = 2'b01;
                            res_data_d = op1_q - op2_q;
                        end
                    end
                    4'd5: begin
                        res_resp_d = 2'b01;
                        res_data_d = op1_q << op2_q[4:0];
                    end
                    4'd6: begin
                        res_resp_d = 2'b01;
                        res_data_d = op1_q >> op2_q[4:0];
                    end
                    default: begin
                        res_resp_d = 2'b11;
                        res_data_d = '0;
                    end
                endcase
            end

            always_ff @(posedge c_clk) begin
                if (!reset) begin
                    state_q    <= ST_IDLE;
                    cmd_q      <= '0;
                    op1_q      <= '0;
                    op2_q      <= '0;
                    res_resp_q <= '0;
                    res_data_q <= '0;
                    resp_q     <= '0;
                    dout_q     <= '0;
                end else begin
                    // Outputs are a one-cycle pulse: cleared unless leaving RESP.
                    resp_q <= 2'b00;
                    dout_q <= '0;
                    case (state_q)
                        // RESP also accepts a new command so back-to-back
                        // operations overlap the response cycle.
                        ST_IDLE, ST_RESP: begin
                            if (state_q == ST_RESP) begin
                                resp_q <= res_resp_q;
                                dout_q <= res_data_q;
                            end
                            if (cmd_i[g] != 4'd0) begin
                                cmd_q   <= cmd_i[g];
                                op1_q   <= data_i[g];
                                state_q <= ST_OP2;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end
                        ST_OP2: begin
                            op2_q   <= data_i[g];
                            state_q <= ST_EXEC;
                        end
                        ST_EXEC: begin
                            res_resp_q <= res_resp_d;
                            res_data_q <= res_data_d;
                            state_q    <= ST_RESP;
                        end
                        default: state_q <= ST_IDLE;
                    endcase
                end
            end

            assign resp_o[g] = resp_q;
            assign dout_o[g] = dout_q;
        end
    endgenerate
endmodule

// File: tb/tb_calc1.sv
// Testbench for calc1: directed vectors plus randomized traffic against an edge-indexed reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_calc1;
    localparam int NCYC = 2400;

    logic c_clk = 1'b0;
    logic reset;

    calc1_if bus ();

    calc1 u_dut (
        .c_clk (c_clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 c_clk = ~c_clk;

    int n_chk  = 0;
    int n_pass = 0;
    int edge_n = 0;

    // Stimulus for the next rising edge.
    logic [3:0]  cmd_v  [4];
    logic [31:0] data_v [4];
    logic        rst_v;

    // Expected outputs indexed by the edge at which they appear.
    logic [1:0]  exp_resp [4][NCYC];
    logic [31:0] exp_data [4][NCYC];

    // Reference model: an accepted command waiting for its second operand.
    bit          pend      [4];
    int          pend_edge [4];
    int          next_ok   [4];
    logic [3:0]  pcmd      [4];
    logic [31:0] pop1      [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic void ref_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                   output logic [1:0] r, output logic [31:0] d);
        longint unsigned s;
        s = 64'(a) + 64'(b);
        r = 2'd3;
        d = '0;
        case (c)
            4'd1: if (s >= 64'h1_0000_0000) r = 2'd2; else begin r = 2'd1; d = s[31:0]; end
            4'd2: if (b > a) r = 2'd2; else begin r = 2'd1; d = a - b; end
            4'd5: begin r = 2'd1; d = a << (b % 32); end
            4'd6: begin r = 2'd1; d = a >> (b % 32); end
            default: begin r = 2'd3; d = '0; end
        endcase
    endfunction

    function automatic logic [1:0] get_resp(input int p);
        case (p)
            0: return bus.out_resp1;
            1: return bus.out_resp2;
            2: return bus.out_resp3;
            default: return bus.out_resp4;
        endcase
    endfunction

    function automatic logic [31:0] get_data(input int p);
        case (p)
            0: return bus.out_data1;
            1: return bus.out_data2;
            2: return bus.out_data3;
            default: return bus.out_data4;
        endcase
    endfunction

    function automatic void model_edge();
        logic [1:0]  r;
        logic [31:0] d;
        for (int p = 0; p < 4; p++) begin
            if (!rst_v) begin
                pend[p]    = 1'b0;
                next_ok[p] = edge_n + 1;
                for (int c = edge_n; c <= edge_n + 3; c++) begin
                    exp_resp[p][c] = '0;
                    exp_data[p][c] = '0;
                end
            end else begin
                if (pend[p] && edge_n == pend_edge[p] + 1) begin
                    ref_op(pcmd[p], pop1[p], data_v[p], r, d);
                    exp_resp[p][pend_edge[p] + 3] = r;
                    exp_data[p][pend_edge[p] + 3] = d;
                    pend[p] = 1'b0;
                end
                if (edge_n >= next_ok[p] && cmd_v[p] != 4'd0) begin
                    pend[p]      = 1'b1;
                    pend_edge[p] = edge_n;
                    pcmd[p]      = cmd_v[p];
                    pop1[p]      = data_v[p];
                    next_ok[p]   = edge_n + 3;
                end
            end
        end
    endfunction

    task automatic clear_v();
        for (int p = 0; p < 4; p++) begin
            cmd_v[p]  = '0;
            data_v[p] = '0;
        end
    endtask

    // Apply stimulus, advance one edge, check all ports against the model.
    task automatic step();
        bus.req1_cmd_in  = cmd_v[0];
        bus.req2_cmd_in  = cmd_v[1];
        bus.req3_cmd_in  = cmd_v[2];
        bus.req4_cmd_in  = cmd_v[3];
        bus.req1_data_in = data_v[0];
        bus.req2_data_in = data_v[1];
        bus.req3_data_in = data_v[2];
        bus.req4_data_in = data_v[3];
        reset            = rst_v;
        @(posedge c_clk);
        edge_n++;
        model_edge();
        @(negedge c_clk);
        for (int p = 0; p < 4; p++) begin
            check($sformatf("resp%0d@%0d", p + 1, edge_n), 32'(get_resp(p)), 32'(exp_resp[p][edge_n]));
            check($sformatf("data%0d@%0d", p + 1, edge_n), get_data(p), exp_data[p][edge_n]);
        end
    endtask

    // One operation on port p; operand2 cycle carries a junk command that must be ignored.
    task automatic run_op(input int p, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] er, input logic [31:0] ed);
        clear_v(); cmd_v[p] = c; data_v[p] = a;
        step();
        clear_v(); cmd_v[p] = 4'hF; data_v[p] = b;
        step();
        clear_v();
        step();
        step();
        check($sformatf("op_resp%0d", p + 1), 32'(get_resp(p)), 32'(er));
        check($sformatf("op_data%0d", p + 1), get_data(p), ed);
        step();
        check($sformatf("op_idle_resp%0d", p + 1), 32'(get_resp(p)), 32'd0);
    endtask

    initial begin
        for (int p = 0; p < 4; p++) begin
            pend[p] = 1'b0; pend_edge[p] = 0; next_ok[p] = 0; pcmd[p] = '0; pop1[p] = '0;
            for (int c = 0; c < NCYC; c++) begin
                exp_resp[p][c] = '0;
                exp_data[p][c] = '0;
            end
        end
        clear_v();
        rst_v = 1'b0;
        repeat (3) step();
        rst_v = 1'b1;

        // First command lands on the first edge with reset high.
        run_op(0, 4'd1, 32'h0000_0001, 32'h0000_0002, 2'd1, 32'h0000_0003);
        run_op(1, 4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 32'h0);
        run_op(2, 4'd2, 32'd5, 32'd6, 2'd2, 32'h0);
        run_op(2, 4'd2, 32'd6, 32'd5, 2'd1, 32'd1);
        run_op(3, 4'd5, 32'h0000_0001, 32'h0000_0024, 2'd1, 32'h0000_0010);
        run_op(3, 4'd6, 32'h8000_0000, 32'd31, 2'd1, 32'h0000_0001);

        // Invalid command on all ports at once.
        clear_v();
        for (int p = 0; p < 4; p++) begin cmd_v[p] = 4'd3; data_v[p] = 32'(p + 7); end
        step();
        clear_v();
        for (int p = 0; p < 4; p++) data_v[p] = 32'(p + 1);
        step();
        clear_v();
        step();
        step();
        for (int p = 0; p < 4; p++) begin
            check($sformatf("inv_resp%0d", p + 1), 32'(get_resp(p)), 32'd3);
            check($sformatf("inv_data%0d", p + 1), get_data(p), 32'd0);
        end
        step();

        // Reset at k+2 of an add aborts it.
        clear_v(); cmd_v[0] = 4'd1; data_v[0] = 32'd5;
        step();
        clear_v(); data_v[0] = 32'd6;
        step();
        clear_v(); rst_v = 1'b0;
        step();
        rst_v = 1'b1;
        step();
        for (int p = 0; p < 4; p++) begin
            check($sformatf("abort_resp%0d", p + 1), 32'(get_resp(p)), 32'd0);
            check($sformatf("abort_data%0d", p + 1), get_data(p), 32'd0);
        end
        step();

        // Randomized traffic with occasional reset pulses.
        for (int i = 0; i < 1800; i++) begin
            for (int p = 0; p < 4; p++) begin
                case ($urandom_range(0, 9))
                    0, 1, 2: cmd_v[p] = 4'd0;
                    3, 4:    cmd_v[p] = 4'd1;
                    5, 6:    cmd_v[p] = 4'd2;
                    7:       cmd_v[p] = 4'd5;
                    8:       cmd_v[p] = 4'd6;
                    default: cmd_v[p] = 4'($urandom_range(0, 15));
                endcase
                case ($urandom_range(0, 7))
                    0:       data_v[p] = 32'hFFFF_FFFF;
                    1:       data_v[p] = 32'h8000_0000;
                    2:       data_v[p] = 32'($urandom_range(0, 40));
                    default: data_v[p] = $urandom;
                endcase
            end
            rst_v = ($urandom_range(0, 199) != 0);
            step();
        end
        clear_v();
        rst_v = 1'b1;
        repeat (5) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
